// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// PipeStageReg : generic pipeline-stage register for the MiniMotorway RV32 core
//
// Holds one entry (SKID=0) or up to two entries (SKID=1) between two pipeline
// stages, with a valid/ready handshake on both sides. The payload is split in
// two parts. The control part reads as CTRL_BUBBLE, a no-op, whenever the
// stage has no valid entry. The data part keeps its last loaded value and is
// cleared only by reset.
//
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous, active-high reset
//   i_valid  upstream entry valid
//   o_ready  stage can accept an entry this cycle
//   i_ctrl   upstream control payload   [CTRL_W]
//   i_data   upstream data payload      [DATA_W]
//   i_flush  synchronous kill of all held entries (branch/jump redirect)
//   o_valid  downstream entry valid
//   i_ready  downstream accepts the entry this cycle
//   o_ctrl   control to next stage      [CTRL_W]
//   o_data   data to next stage         [DATA_W]
//   o_count  number of entries held (0..2)
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                 CTRL_W      = 16,
    parameter int                 DATA_W      = 165,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = 16'h0002,
    parameter bit                 SKID        = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    // Main register: the entry currently presented downstream.
    logic              r_mainValid;
    logic [CTRL_W-1:0] r_mainCtrl;
    logic [DATA_W-1:0] r_mainData;

    // Skid register: catches the entry accepted while the main register
    // stalls, so that the upstream ready can come from a flop.
    logic              r_skidValid;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic [DATA_W-1:0] r_skidData;

    logic              r_ready;
    logic [1:0]        r_count;

    logic              w_accept;
    logic              w_issue;

    logic              w_mainValidNext;
    logic [CTRL_W-1:0] w_mainCtrlNext;
    logic [DATA_W-1:0] w_mainDataNext;
    logic              w_skidValidNext;
    logic [CTRL_W-1:0] w_skidCtrlNext;
    logic [DATA_W-1:0] w_skidDataNext;

    // With the skid buffer present, ready comes straight from a flop. Without
    // it, the single register can take a new entry whenever it is empty or
    // its current entry leaves this cycle.
    assign o_ready  = SKID ? r_ready : (i_ready | ~r_mainValid);

    assign w_accept = i_valid & o_ready;
    assign w_issue  = r_mainValid & i_ready;

    assign o_valid  = r_mainValid;
    assign o_ctrl   = r_mainValid ? r_mainCtrl : CTRL_BUBBLE;
    assign o_data   = r_mainData;
    assign o_count  = r_count;

    // Next-state logic for both entry slots. The main register always holds
    // the oldest entry, so draining the skid into main preserves FIFO order.
    // While the skid is full, o_ready is low and no new entry can arrive.
    // In the SKID=0 build, an accept implies the main register is empty or
    // issuing, so the skid path is never taken.
    always_comb begin
        w_mainValidNext = r_mainValid;
        w_mainCtrlNext  = r_mainCtrl;
        w_mainDataNext  = r_mainData;
        w_skidValidNext = r_skidValid;
        w_skidCtrlNext  = r_skidCtrl;
        w_skidDataNext  = r_skidData;

        if (i_flush) begin
            // Drop everything. Any issue this cycle has already been seen
            // downstream, and any offered input is discarded.
            w_mainValidNext = 1'b0;
            w_mainCtrlNext  = CTRL_BUBBLE;
            w_skidValidNext = 1'b0;
        end else if (r_skidValid) begin
            if (w_issue) begin
                w_mainValidNext = 1'b1;
                w_mainCtrlNext  = r_skidCtrl;
                w_mainDataNext  = r_skidData;
                w_skidValidNext = 1'b0;
            end
        end else if (w_accept && (!r_mainValid || w_issue)) begin
            w_mainValidNext = 1'b1;
            w_mainCtrlNext  = i_ctrl;
            w_mainDataNext  = i_data;
        end else if (w_accept) begin
            // Main is full and stalled, so park the new entry in the skid.
            w_skidValidNext = 1'b1;
            w_skidCtrlNext  = i_ctrl;
            w_skidDataNext  = i_data;
        end else if (w_issue) begin
            w_mainValidNext = 1'b0;
            w_mainCtrlNext  = CTRL_BUBBLE;
        end
    end

    // State registers. Reset wins over flush. Flush is folded into the next
    // state above. Ready and count are registered from the next state so
    // that neither adds a combinational path to the neighbouring stages.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mainValid <= 1'b0;
            r_mainCtrl  <= CTRL_BUBBLE;
            r_mainData  <= '0;
            r_skidValid <= 1'b0;
            r_skidCtrl  <= CTRL_BUBBLE;
            r_skidData  <= '0;
            r_ready     <= 1'b1;
            r_count     <= 2'd0;
        end else begin
            r_mainValid <= w_mainValidNext;
            r_mainCtrl  <= w_mainCtrlNext;
            r_mainData  <= w_mainDataNext;
            r_skidValid <= w_skidValidNext;
            r_skidCtrl  <= w_skidCtrlNext;
            r_skidData  <= w_skidDataNext;
            r_ready     <= ~w_skidValidNext;
            r_count     <= {1'b0, w_mainValidNext} + {1'b0, w_skidValidNext};
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg : bench for pipe_stage_reg
//
// Two instances share one set of inputs: dutSkid (SKID=1) and dutNoSkid
// (SKID=0). Each instance has a FIFO reference model: a small array of
// entries plus an occupancy count. The bench runs directed scenarios and then
// random traffic, and checks every output of both instances after each clock
// edge.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int              CTRL_W = 16;
    localparam int              DATA_W = 165;
    localparam logic [15:0]     BUBBLE = 16'h0002;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic              flush;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    logic              sReady, sValid;
    logic [CTRL_W-1:0] sCtrl;
    logic [DATA_W-1:0] sData;
    logic [1:0]        sCount;

    logic              nReady, nValid;
    logic [CTRL_W-1:0] nCtrl;
    logic [DATA_W-1:0] nData;
    logic [1:0]        nCount;

    // Reference model state. Index 0 models SKID=1 and index 1 models SKID=0.
    logic [CTRL_W-1:0] mCtrl  [2][3];
    logic [DATA_W-1:0] mData  [2][3];
    int                mSize  [2];
    logic              mReadyFlag [2];
    logic [DATA_W-1:0] mLast  [2];

    int checks;
    int errors;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(BUBBLE), .SKID(1'b1)) dutSkid (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(sReady),
        .i_ctrl(ctrl), .i_data(data), .i_flush(flush), .o_valid(sValid),
        .i_ready(ready), .o_ctrl(sCtrl), .o_data(sData), .o_count(sCount)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(BUBBLE), .SKID(1'b0)) dutNoSkid (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(nReady),
        .i_ctrl(ctrl), .i_data(data), .i_flush(flush), .o_valid(nValid),
        .i_ready(ready), .o_ctrl(nCtrl), .o_data(nData), .o_count(nCount)
    );

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] randData();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // Drives one cycle of inputs, steps both models across the clock edge,
    // then compares every output of both instances with its model.
    task automatic applyStimulus(input logic r, input logic v, input logic f,
                                 input logic rd, input logic [CTRL_W-1:0] c,
                                 input logic [DATA_W-1:0] d);
        logic acc [2];
        logic iss;
        logic expReady;
        rst = r; valid = v; flush = f; ready = rd; ctrl = c; data = d;
        acc[0] = v && mReadyFlag[0];
        acc[1] = v && (rd || mSize[1] == 0);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                mSize[m] = 0;
                mReadyFlag[m] = 1'b1;
                mLast[m] = '0;
            end else if (f) begin
                mSize[m] = 0;
                mReadyFlag[m] = 1'b1;
            end else begin
                iss = (mSize[m] > 0) && rd;
                if (iss) begin
                    for (int k = 0; k < 2; k++) begin
                        mCtrl[m][k] = mCtrl[m][k+1];
                        mData[m][k] = mData[m][k+1];
                    end
                    mSize[m]--;
                end
                if (acc[m]) begin
                    mCtrl[m][mSize[m]] = c;
                    mData[m][mSize[m]] = d;
                    mSize[m]++;
                end
                mReadyFlag[m] = (mSize[m] < 2);
            end
            if (mSize[m] > 0) mLast[m] = mData[m][0];
        end

        checkOutput("skid.valid", DATA_W'(sValid), DATA_W'(mSize[0] > 0));
        checkOutput("skid.ctrl",  DATA_W'(sCtrl),  DATA_W'((mSize[0] > 0) ? mCtrl[0][0] : BUBBLE));
        checkOutput("skid.data",  sData,           mLast[0]);
        checkOutput("skid.count", DATA_W'(sCount), DATA_W'(mSize[0]));
        checkOutput("skid.ready", DATA_W'(sReady), DATA_W'(mReadyFlag[0]));

        expReady = rd || (mSize[1] == 0);
        checkOutput("noskid.valid", DATA_W'(nValid), DATA_W'(mSize[1] > 0));
        checkOutput("noskid.ctrl",  DATA_W'(nCtrl),  DATA_W'((mSize[1] > 0) ? mCtrl[1][0] : BUBBLE));
        checkOutput("noskid.data",  nData,           mLast[1]);
        checkOutput("noskid.count", DATA_W'(nCount), DATA_W'(mSize[1]));
        checkOutput("noskid.ready", DATA_W'(nReady), DATA_W'(expReady));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int m = 0; m < 2; m++) begin
            mSize[m] = 0;
            mReadyFlag[m] = 1'b1;
            mLast[m] = '0;
        end
        rst = 1'b1; valid = 1'b0; flush = 1'b0; ready = 1'b0; ctrl = '0; data = '0;

        // Reset held for two cycles while garbage is offered.
        applyStimulus(1, 1, 0, 0, 16'hFFFF, '1);
        applyStimulus(1, 1, 0, 0, 16'hFFFF, '1);
        applyStimulus(0, 0, 0, 0, 16'h0000, '0);

        // Back-to-back streaming.
        for (int i = 1; i <= 4; i++)
            applyStimulus(0, 1, 0, 1, 16'(16'h0100 + i), DATA_W'(i));
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);

        // Stall fill with A and B, C held off, then drain.
        applyStimulus(0, 1, 0, 0, 16'h0A0A, DATA_W'(32'hA));
        applyStimulus(0, 1, 0, 0, 16'h0B0B, DATA_W'(32'hB));
        applyStimulus(0, 1, 0, 0, 16'h0C0C, DATA_W'(32'hC));
        applyStimulus(0, 1, 0, 1, 16'h0C0C, DATA_W'(32'hC));
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);

        // Flush with the skid full while C is offered.
        applyStimulus(0, 1, 0, 0, 16'h1A1A, DATA_W'(32'h1A));
        applyStimulus(0, 1, 0, 0, 16'h1B1B, DATA_W'(32'h1B));
        applyStimulus(0, 1, 1, 0, 16'h1C1C, DATA_W'(32'h1C));
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);

        // Downstream ready toggling with continuous input.
        applyStimulus(0, 1, 0, 1, 16'h2000, DATA_W'(32'h20));
        applyStimulus(0, 1, 0, 0, 16'h2001, DATA_W'(32'h21));
        applyStimulus(0, 1, 0, 1, 16'h2001, DATA_W'(32'h21));
        applyStimulus(0, 1, 0, 0, 16'h2002, DATA_W'(32'h22));
        applyStimulus(0, 1, 0, 1, 16'h2002, DATA_W'(32'h22));
        applyStimulus(0, 1, 0, 1, 16'h2003, DATA_W'(32'h23));
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);

        // Reset asserted while stalled with the skid full, then a lone Y.
        applyStimulus(0, 1, 0, 0, 16'h3A3A, DATA_W'(32'h3A));
        applyStimulus(0, 1, 0, 0, 16'h3B3B, DATA_W'(32'h3B));
        applyStimulus(1, 0, 0, 0, 16'h0000, '0);
        applyStimulus(0, 1, 0, 0, 16'h5959, DATA_W'(32'h59));
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);
        applyStimulus(0, 0, 0, 1, 16'h0000, '0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(63) == 0),
                          ($urandom_range(3) != 0),
                          ($urandom_range(15) == 0),
                          ($urandom_range(2) != 0),
                          16'($urandom()),
                          randData());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
